// File: rtl/ucisc_pkg.sv
// ============================================================================
// Module  : ucisc_pkg
// Brief   : Shared types and encodings for the uCISC write-back stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ucisc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } wb_state_t;

    localparam logic [1:0] INC_NONE = 2'b00;
    localparam logic [1:0] INC_UP   = 2'b01;
    localparam logic [1:0] INC_DOWN = 2'b10;

    localparam logic [1:0] STEP_0 = 2'd0;
    localparam logic [1:0] STEP_1 = 2'd1;
    localparam logic [1:0] STEP_2 = 2'd2;
    localparam logic [1:0] STEP_3 = 2'd3;

endpackage

`default_nettype wire

// File: rtl/result_writer_if.sv
// ============================================================================
// Module  : result_writer_if
// Brief   : Sequencer/memory/register-file bundle around the write-back stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface result_writer_if #(
    parameter int WIDTH = 16
);
    logic [1:0]       step;
    logic [1:0]       write_on;
    logic             enable;
    logic             is_mem;
    logic [1:0]       inc_mode;
    logic [WIDTH-1:0] immediate;
    logic [WIDTH-1:0] dest_reg_value;
    logic [WIDTH-1:0] result;
    logic             mem_ready;
    logic             mem_write;
    logic [WIDTH-1:0] write_address;
    logic [WIDTH-1:0] write_data;
    logic             reg_write;
    logic [WIDTH-1:0] reg_value;
    logic             stall;
    logic             write_error;

    modport master (
        output step, write_on, enable, is_mem, inc_mode,
               immediate, dest_reg_value, result, mem_ready,
        input  mem_write, write_address, write_data,
               reg_write, reg_value, stall, write_error
    );

    modport slave (
        input  step, write_on, enable, is_mem, inc_mode,
               immediate, dest_reg_value, result, mem_ready,
        output mem_write, write_address, write_data,
               reg_write, reg_value, stall, write_error
    );

endinterface

`default_nettype wire

// File: rtl/wait_counter.sv
// ============================================================================
// Module  : wait_counter
// Brief   : Counts active cycles and flags the cycle in which MAX is reached.
// Revision: 1.0
// ============================================================================
`default_nettype none

module wait_counter #(
    parameter int MAX = 15
) (
    input  wire logic clock,
    input  wire logic reset_n,
    input  wire logic clear,
    input  wire logic count,
    output logic      expired
);
    localparam int             CW     = $clog2(MAX + 1);
    localparam logic [CW-1:0]  C_LAST = CW'(MAX - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (count) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Fires during the MAX-th counted cycle so the owner can leave on that edge.
    assign expired = count && (r_count == C_LAST);

endmodule

`default_nettype wire

// File: rtl/result_writer.sv
// ============================================================================
// Module  : result_writer
// Brief   : uCISC write-back: memory handshake or register strobe, optional
//           post-inc/dec of the destination register, stall until committed.
// Revision: 1.0
// ============================================================================
`default_nettype none

module result_writer
    import ucisc_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int MAX_WAIT = 15
) (
    input  wire logic      clock,
    input  wire logic      reset_n,
    result_writer_if.slave bus
);
    wb_state_t        r_state;
    wb_state_t        w_next;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_upd;
    logic             r_is_mem;
    logic             r_inc_en;
    logic             r_error;
    logic             w_trigger;
    logic             w_expired;
    logic             w_stall;
    logic             w_mem_write;
    logic             w_reg_write;
    logic [WIDTH-1:0] w_reg_value;

    // Gated by reset_n so a held trigger cannot raise stall while in reset.
    assign w_trigger = reset_n && (r_state == IDLE) &&
                       (bus.step == bus.write_on) && bus.enable;

    wait_counter #(
        .MAX (MAX_WAIT)
    ) u_wait_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (r_state != ISSUE),
        .count   (r_state == ISSUE),
        .expired (w_expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_stall     = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        w_reg_value = '0;
        case (r_state)
            IDLE: begin
                if (w_trigger) begin
                    w_stall = 1'b1;
                    w_next  = bus.is_mem ? ISSUE : COMMIT;
                end
            end
            ISSUE: begin
                w_stall     = 1'b1;
                w_mem_write = 1'b1;
                if (bus.mem_ready || w_expired) begin
                    w_next = COMMIT;
                end
            end
            COMMIT: begin
                w_next = DONE;
                if (!r_is_mem) begin
                    w_reg_write = 1'b1;
                    w_reg_value = r_data;
                end else if (r_inc_en) begin
                    w_reg_write = 1'b1;
                    w_reg_value = r_upd;
                end
            end
            DONE: begin
                if (bus.step != bus.write_on) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_addr   <= '0;
            r_data   <= '0;
            r_upd    <= '0;
            r_is_mem <= 1'b0;
            r_inc_en <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            if (w_trigger) begin
                r_addr   <= bus.dest_reg_value + bus.immediate;
                r_data   <= bus.result;
                r_upd    <= (bus.inc_mode == INC_DOWN) ? bus.dest_reg_value - WIDTH'(1)
                                                       : bus.dest_reg_value + WIDTH'(1);
                r_is_mem <= bus.is_mem;
                r_inc_en <= (bus.inc_mode == INC_UP) || (bus.inc_mode == INC_DOWN);
            end
            // A ready seen on the expiry edge still counts as a transfer.
            if ((r_state == ISSUE) && !bus.mem_ready && w_expired) begin
                r_error <= 1'b1;
            end
        end
    end

    assign bus.mem_write     = w_mem_write;
    assign bus.write_address = w_mem_write ? r_addr : '0;
    assign bus.write_data    = w_mem_write ? r_data : '0;
    assign bus.reg_write     = w_reg_write;
    assign bus.reg_value     = w_reg_value;
    assign bus.stall         = w_stall;
    assign bus.write_error   = r_error;

endmodule

`default_nettype wire

// File: tb/tb_result_writer.sv
// ============================================================================
// Module  : tb_result_writer
// Brief   : Directed and randomized transactions against a transaction-level model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_result_writer;
    localparam int WIDTH    = 16;
    localparam int MAX_WAIT = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    result_writer_if #(.WIDTH(WIDTH)) bus ();

    result_writer #(
        .WIDTH    (WIDTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus.slave)
    );

    int   n_checks  = 0;
    int   n_pass    = 0;
    logic err_model = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_stall"}, 32'(bus.stall), 32'd0);
        check({tag, "_memw"},  32'(bus.mem_write), 32'd0);
        check({tag, "_regw"},  32'(bus.reg_write), 32'd0);
        check({tag, "_err"},   32'(bus.write_error), 32'(err_model));
    endtask

    task automatic scramble();
        bus.dest_reg_value = 16'($urandom);
        bus.immediate      = 16'($urandom);
        bus.result         = 16'($urandom);
        bus.is_mem         = 1'($urandom);
        bus.inc_mode       = 2'($urandom);
    endtask

    // delay = mem_ready-low cycles before ready; hold = extra cycles step stays at write_on
    task automatic run_txn(input logic [1:0] won, input logic [15:0] dest, input logic [15:0] imm,
                           input logic [15:0] res, input logic mem, input logic [1:0] inc,
                           input int delay, input int hold);
        logic [15:0] addr, upd, rv;
        bit          strobe, timeout;
        int          issue_n;
        addr    = dest + imm;
        upd     = (inc == 2'b10) ? dest - 16'd1 : dest + 16'd1;
        strobe  = !mem || (inc == 2'b01) || (inc == 2'b10);
        rv      = mem ? upd : res;
        timeout = mem && (delay >= MAX_WAIT);
        issue_n = !mem ? 0 : (timeout ? MAX_WAIT : delay + 1);

        @(negedge clk);
        bus.write_on = won;  bus.step = won;  bus.enable = 1'b1;
        bus.is_mem = mem;  bus.inc_mode = inc;
        bus.dest_reg_value = dest;  bus.immediate = imm;  bus.result = res;
        bus.mem_ready = 1'b0;
        #1;
        check("trig_stall", 32'(bus.stall), 32'd1);
        check("trig_memw",  32'(bus.mem_write), 32'd0);
        check("trig_regw",  32'(bus.reg_write), 32'd0);

        for (int k = 0; k < issue_n; k++) begin
            @(negedge clk);
            scramble();
            bus.enable    = 1'($urandom);
            bus.mem_ready = (k >= delay);
            #1;
            check("issue_memw",  32'(bus.mem_write), 32'd1);
            check("issue_addr",  32'(bus.write_address), 32'(addr));
            check("issue_data",  32'(bus.write_data), 32'(res));
            check("issue_stall", 32'(bus.stall), 32'd1);
            check("issue_regw",  32'(bus.reg_write), 32'd0);
            check("issue_err",   32'(bus.write_error), 32'(err_model));
        end
        if (timeout) err_model = 1'b1;

        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.enable    = 1'b1;
        #1;
        check("commit_regw",  32'(bus.reg_write), 32'(strobe));
        if (strobe) check("commit_rval", 32'(bus.reg_value), 32'(rv));
        check("commit_stall", 32'(bus.stall), 32'd0);
        check("commit_memw",  32'(bus.mem_write), 32'd0);
        check("commit_err",   32'(bus.write_error), 32'(err_model));

        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            scramble();
            #1;
            check_quiet("hold");
        end

        @(negedge clk);
        bus.step = won + 2'd1;
        #1;
        check_quiet("release");
    endtask

    initial begin
        bus.step = 2'd0;  bus.write_on = 2'd2;  bus.enable = 1'b0;
        bus.is_mem = 1'b0;  bus.inc_mode = 2'b00;
        bus.immediate = '0;  bus.dest_reg_value = '0;  bus.result = '0;
        bus.mem_ready = 1'b0;
        #1;
        check("rst_memw",  32'(bus.mem_write), 32'd0);
        check("rst_addr",  32'(bus.write_address), 32'd0);
        check("rst_data",  32'(bus.write_data), 32'd0);
        check("rst_regw",  32'(bus.reg_write), 32'd0);
        check("rst_rval",  32'(bus.reg_value), 32'd0);
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_err",   32'(bus.write_error), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_txn(2'd2, 16'h0010, 16'h0003, 16'hBEEF, 1'b0, 2'b00, 0, 0);
        run_txn(2'd2, 16'h1000, 16'h0020, 16'h55AA, 1'b1, 2'b00, 3, 0);
        run_txn(2'd1, 16'hFFFF, 16'h0002, 16'h1234, 1'b1, 2'b01, 0, 0);
        run_txn(2'd3, 16'h0000, 16'h0005, 16'h0F0F, 1'b1, 2'b10, 1, 0);
        run_txn(2'd0, 16'h00FF, 16'h0001, 16'hCAFE, 1'b0, 2'b01, 0, 5);

        // no-op instruction sitting on the write step must not write
        @(negedge clk);
        bus.write_on = 2'd1;  bus.step = 2'd1;  bus.enable = 1'b0;
        #1;
        check_quiet("noop");
        run_txn(2'd1, 16'h2222, 16'h0001, 16'h3333, 1'b0, 2'b00, 0, 1);

        run_txn(2'd2, 16'h4000, 16'h0004, 16'hA5A5, 1'b1, 2'b00, 14, 0);
        run_txn(2'd2, 16'h4000, 16'h0008, 16'h5A5A, 1'b1, 2'b01, 15, 2);
        run_txn(2'd0, 16'h0100, 16'h0010, 16'h7777, 1'b1, 2'b00, 0, 0);

        for (int i = 0; i < 30; i++) begin
            int d;
            d = ($urandom_range(0, 5) == 0) ? int'($urandom_range(13, 18))
                                            : int'($urandom_range(0, 4));
            run_txn(2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    1'($urandom), 2'($urandom), d, int'($urandom_range(0, 4)));
        end

        // reset in the middle of a memory write
        @(negedge clk);
        bus.write_on = 2'd3;  bus.step = 2'd3;  bus.enable = 1'b1;
        bus.is_mem = 1'b1;  bus.inc_mode = 2'b01;
        bus.dest_reg_value = 16'h0800;  bus.immediate = 16'h0002;  bus.result = 16'h1111;
        bus.mem_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("pre_rst_memw", 32'(bus.mem_write), 32'd1);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_memw",  32'(bus.mem_write), 32'd0);
        check("midrst_addr",  32'(bus.write_address), 32'd0);
        check("midrst_stall", 32'(bus.stall), 32'd0);
        check("midrst_regw",  32'(bus.reg_write), 32'd0);
        check("midrst_err",   32'(bus.write_error), 32'd0);
        err_model  = 1'b0;
        bus.step   = 2'd0;
        bus.enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            check_quiet("post_rst");
        end
        run_txn(2'd3, 16'h0800, 16'h0002, 16'h1111, 1'b1, 2'b01, 2, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
